// File: rtl/eth_pkg.sv
// eth_pkg: shared state enum and MII register constants for the PHY management sequencer
package eth_pkg;
  typedef enum logic [2:0] {WAIT_RST, SRST_WR, SRST_RD, AN_WR, IDLE, POLL_RD, HOST} seq_state_t;
  localparam logic [4:0] MII_BMCR = 5'd0;
  localparam logic [4:0] MII_BMSR = 5'd1;
  localparam logic [15:0] BMCR_SRST = 16'h8000;
  localparam logic [15:0] BMCR_AN_INIT = 16'h1200;
  localparam int BMSR_LINK = 2;
  localparam int BMSR_AN_DONE = 5;
endpackage

// File: rtl/eth_dm_txn.sv
// eth_dm_txn: issues one DM transaction, holds its fields and reports done or timeout
module eth_dm_txn import eth_pkg::*; #(
  parameter int DM_TIMEOUT = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        go,
  input  logic        mode,
  input  logic [4:0]  reg_addr,
  input  logic [15:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        timeout,
  output logic [15:0] rdata,
  output logic        dm_start,
  output logic        dm_mode,
  output logic [4:0]  dm_reg_addr,
  output logic [15:0] dm_data_i,
  input  logic [15:0] dm_data_o,
  input  logic        dm_done
);
  logic [16:0] tcnt;
  assign done = busy & dm_done;
  assign timeout = busy & ~dm_done & (tcnt >= 17'(DM_TIMEOUT));
  assign rdata = (done && !dm_mode) ? dm_data_o : '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= 1'b0;
      tcnt <= '0;
      dm_start <= 1'b0;
      dm_mode <= 1'b0;
      dm_reg_addr <= '0;
      dm_data_i <= '0;
    end else begin
      dm_start <= go;
      if (go) begin
        busy <= 1'b1;
        tcnt <= '0;
        dm_mode <= mode;
        dm_reg_addr <= reg_addr;
        dm_data_i <= wdata;
      end else if (done || timeout) begin
        busy <= 1'b0;
      end else if (busy) begin
        tcnt <= tcnt + 17'd1;
      end
    end
  end
endmodule

// File: rtl/eth_phy_mgmt_seq.sv
// eth_phy_mgmt_seq: PHY reset/auto-neg init, periodic BMSR polling and host access arbitration over one DM engine
module eth_phy_mgmt_seq import eth_pkg::*; #(
  parameter logic [4:0] PHY_ADDR = 5'd1,
  parameter int RESET_WAIT = 100000,
  parameter int POLL_INTERVAL = 1000000,
  parameter int DM_TIMEOUT = 100000,
  parameter int SRST_POLLS = 16
) (
  input  logic        clk_100_mhz,
  input  logic        rst,
  output logic        DM_start,
  output logic        DM_mode,
  output logic [4:0]  DM_addr,
  output logic [4:0]  DM_reg_addr,
  output logic [15:0] DM_data_i,
  input  logic [15:0] DM_data_o,
  input  logic        DM_done,
  input  logic        host_req,
  input  logic        host_write,
  input  logic [4:0]  host_reg,
  input  logic [15:0] host_wdata,
  output logic        host_ack,
  output logic [15:0] host_rdata,
  output logic        host_err,
  output logic        link_up,
  output logic        an_done,
  output logic        init_done,
  output logic        init_error
);
  seq_state_t state;
  logic [19:0] pcnt;
  logic [7:0] srst_cnt;
  logic go, busy, done, timeout, fin, mode;
  logic [4:0] reg_addr;
  logic [15:0] wdata, rdata;
  assign DM_addr = PHY_ADDR;
  assign go = !(state inside {WAIT_RST, IDLE}) && !busy;
  assign fin = done | timeout;
  assign mode = (state == HOST) ? host_write : (state == SRST_WR || state == AN_WR);
  assign reg_addr = (state == HOST) ? host_reg : (state == POLL_RD) ? MII_BMSR : MII_BMCR;
  assign wdata = (state == HOST) ? host_wdata : (state == SRST_WR) ? BMCR_SRST :
                 (state == AN_WR) ? BMCR_AN_INIT : '0;
  eth_dm_txn #(.DM_TIMEOUT(DM_TIMEOUT)) u_txn (
    .clk(clk_100_mhz), .rst(rst), .go(go), .mode(mode), .reg_addr(reg_addr), .wdata(wdata),
    .busy(busy), .done(done), .timeout(timeout), .rdata(rdata),
    .dm_start(DM_start), .dm_mode(DM_mode), .dm_reg_addr(DM_reg_addr), .dm_data_i(DM_data_i),
    .dm_data_o(DM_data_o), .dm_done(DM_done)
  );
  always_ff @(posedge clk_100_mhz) begin
    if (rst) begin
      state <= WAIT_RST;
      pcnt <= '0;
      srst_cnt <= '0;
      host_ack <= 1'b0;
      host_rdata <= '0;
      host_err <= 1'b0;
      link_up <= 1'b0;
      an_done <= 1'b0;
      init_done <= 1'b0;
      init_error <= 1'b0;
    end else begin
      host_ack <= 1'b0;
      host_err <= 1'b0;
      pcnt <= (pcnt == '1) ? pcnt : pcnt + 20'd1;
      if (timeout) init_error <= 1'b1;
      case (state)
        WAIT_RST: if (pcnt >= 20'(RESET_WAIT - 1)) state <= SRST_WR;
        SRST_WR:  if (fin) state <= SRST_RD;
        SRST_RD: if (fin) begin
          srst_cnt <= srst_cnt + 8'd1;
          if (!rdata[15]) state <= AN_WR;
          else if (srst_cnt >= 8'(SRST_POLLS - 1)) begin
            init_error <= 1'b1;
            state <= AN_WR;
          end
        end
        AN_WR: if (fin) begin
          init_done <= 1'b1;
          state <= IDLE;
        end
        // a due poll outranks a waiting host; the host is taken on the next IDLE cycle
        IDLE: state <= (pcnt >= 20'(POLL_INTERVAL)) ? POLL_RD : host_req ? HOST : IDLE;
        POLL_RD: if (fin) begin
          link_up <= rdata[BMSR_LINK];
          an_done <= rdata[BMSR_AN_DONE];
          pcnt <= '0;
          state <= IDLE;
        end
        HOST: if (fin) begin
          host_ack <= 1'b1;
          host_err <= timeout;
          host_rdata <= rdata;
          state <= IDLE;
        end
        default: state <= WAIT_RST;
      endcase
    end
  end
endmodule

// File: tb/tb_eth_phy_mgmt_seq.sv
// tb_eth_phy_mgmt_seq: directed checks of init, polling, host access, collision, timeout and reset
module tb_eth_phy_mgmt_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic DM_start, DM_mode, DM_done = 1'b0;
  logic [4:0] DM_addr, DM_reg_addr;
  logic [15:0] DM_data_i, DM_data_o = '0;
  logic host_req = 1'b0, host_write = 1'b0;
  logic [4:0] host_reg = '0;
  logic [15:0] host_wdata = '0;
  logic host_ack, host_err, link_up, an_done, init_done, init_error;
  logic [15:0] host_rdata;
  int checks = 0, errors = 0;
  logic mute = 1'b0, stuck = 1'b0;
  logic [15:0] bmsr = 16'h0024;
  int mcnt = 0, bmcr_reads = 0, n_txn = 0, overlaps = 0;
  logic m_mode;
  logic [4:0] m_reg;
  logic log_mode [256];
  logic [4:0] log_reg [256];
  logic [15:0] log_data [256];

  always #5 clk = ~clk;

  eth_phy_mgmt_seq #(.RESET_WAIT(10), .POLL_INTERVAL(50), .DM_TIMEOUT(30)) dut (
    .clk_100_mhz(clk), .rst(rst), .DM_start(DM_start), .DM_mode(DM_mode), .DM_addr(DM_addr),
    .DM_reg_addr(DM_reg_addr), .DM_data_i(DM_data_i), .DM_data_o(DM_data_o), .DM_done(DM_done),
    .host_req(host_req), .host_write(host_write), .host_reg(host_reg), .host_wdata(host_wdata),
    .host_ack(host_ack), .host_rdata(host_rdata), .host_err(host_err), .link_up(link_up),
    .an_done(an_done), .init_done(init_done), .init_error(init_error)
  );

  // DM engine model: answers 8 cycles after DM_start, logs every request
  always @(posedge clk) begin
    if (rst) begin
      mcnt <= 0;
      DM_done <= 1'b0;
      DM_data_o <= '0;
      bmcr_reads <= 0;
    end else begin
      DM_done <= 1'b0;
      if (DM_start) begin
        if (mcnt != 0 || DM_done) overlaps <= overlaps + 1;
        mcnt <= 7;
        m_mode <= DM_mode;
        m_reg <= DM_reg_addr;
        log_mode[n_txn] <= DM_mode;
        log_reg[n_txn] <= DM_reg_addr;
        log_data[n_txn] <= DM_data_i;
        n_txn <= n_txn + 1;
      end else if (mcnt != 0) begin
        mcnt <= mcnt - 1;
        if (mcnt == 1 && !mute) begin
          DM_done <= 1'b1;
          DM_data_o <= m_mode ? 16'h0 : (m_reg == 5'd0) ? ((stuck || bmcr_reads == 0) ? 16'h8000 : 16'h0000) :
                       (m_reg == 5'd1) ? bmsr : (m_reg == 5'd2) ? 16'h0022 : 16'hDEAD;
          if (!m_mode && m_reg == 5'd0) bmcr_reads <= bmcr_reads + 1;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic cond(input int s);
    return s == 0 ? init_done : s == 1 ? link_up : s == 2 ? DM_start : s == 3 ? host_ack : DM_done;
  endfunction

  task automatic wait_for(input int s, input int lim, input string tag, output int n);
    n = 0;
    while (!cond(s) && n < lim) begin
      step();
      n++;
    end
    check(tag, 32'(cond(s)), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_dm_start"}, 32'(DM_start), 32'd0);
    check({tag, "_dm_mode"}, 32'(DM_mode), 32'd0);
    check({tag, "_dm_addr"}, 32'(DM_addr), 32'd1);
    check({tag, "_dm_reg"}, 32'(DM_reg_addr), 32'd0);
    check({tag, "_dm_data"}, 32'(DM_data_i), 32'd0);
    check({tag, "_host_ack"}, 32'(host_ack), 32'd0);
    check({tag, "_host_rdata"}, 32'(host_rdata), 32'd0);
    check({tag, "_host_err"}, 32'(host_err), 32'd0);
    check({tag, "_link"}, {30'd0, link_up, an_done}, 32'd0);
    check({tag, "_init"}, {30'd0, init_done, init_error}, 32'd0);
  endtask

  initial begin
    int n, n2, base;
    repeat (3) step();
    check_reset_outputs("rst");
    rst = 1'b0;
    // init: SRST write, two BMCR reads, AN write
    wait_for(0, 400, "init_seen", n);
    check("init_ntxn", 32'(n_txn), 32'd4);
    check("init_t0", {15'd0, log_mode[0], 11'd0, log_reg[0]}, {15'd0, 1'b1, 16'd0});
    check("init_t0_data", 32'(log_data[0]), 32'h8000);
    check("init_t1", {log_mode[1], log_reg[1]}, 32'd0);
    check("init_t2", {log_mode[2], log_reg[2]}, 32'd0);
    check("init_t3", {log_mode[3], log_reg[3], log_data[3]}, {1'b1, 5'd0, 16'h1200});
    check("init_error", 32'(init_error), 32'd0);
    // link poll up
    wait_for(4, 200, "poll1_done", n);
    check("poll1_reg", {DM_mode, DM_reg_addr}, 32'd1);
    check("poll1_before", {link_up, an_done}, 32'd0);
    step();
    check("poll1_after", {link_up, an_done}, 32'd3);
    bmsr = 16'h0000;
    step();
    wait_for(4, 200, "poll2_done", n);
    step();
    check("poll2_after", {link_up, an_done}, 32'd0);
    // host read
    host_req = 1'b1;
    host_write = 1'b0;
    host_reg = 5'd2;
    wait_for(2, 20, "hrd_start", n);
    check("hrd_start_lat", 32'(n), 32'd2);
    check("hrd_fields", {DM_mode, DM_reg_addr}, 32'd2);
    wait_for(3, 40, "hrd_ack", n2);
    check("hrd_lat", 32'(n + n2), 32'd11);
    check("hrd_rdata", 32'(host_rdata), 32'h0022);
    check("hrd_err", 32'(host_err), 32'd0);
    host_req = 1'b0;
    step();
    check("hrd_ack_pulse", 32'(host_ack), 32'd0);
    // collision: host_req lands on the cycle the poll counter expires
    wait_for(4, 200, "poll3_done", n);
    repeat (51) step();
    base = n_txn;
    host_req = 1'b1;
    wait_for(3, 100, "col_ack", n);
    host_req = 1'b0;
    check("col_ntxn", 32'(n_txn - base), 32'd2);
    check("col_first_poll", 32'(log_reg[base]), 32'd1);
    check("col_then_host", 32'(log_reg[base + 1]), 32'd2);
    check("col_rdata", 32'(host_rdata), 32'h0022);
    check("col_overlap", 32'(overlaps), 32'd0);
    // host write that the engine never completes
    step();
    mute = 1'b1;
    host_write = 1'b1;
    host_reg = 5'd4;
    host_wdata = 16'h1234;
    host_req = 1'b1;
    base = n_txn;
    wait_for(3, 100, "to_ack", n);
    check("to_lat", 32'(n), 32'd33);
    check("to_err", 32'(host_err), 32'd1);
    check("to_rdata", 32'(host_rdata), 32'd0);
    check("to_init_error", 32'(init_error), 32'd1);
    check("to_txn", {log_mode[base], log_reg[base], log_data[base]}, {1'b1, 5'd4, 16'h1234});
    host_req = 1'b0;
    mute = 1'b0;
    bmsr = 16'h0024;
    wait_for(1, 200, "to_poll_continues", n);
    // reset while a transaction is outstanding; BMCR then never self-clears
    wait_for(2, 200, "mid_start", n);
    rst = 1'b1;
    stuck = 1'b1;
    step();
    check_reset_outputs("mid_rst");
    base = n_txn;
    rst = 1'b0;
    wait_for(0, 600, "reinit_seen", n);
    check("reinit_first", {log_mode[base], log_reg[base], log_data[base]}, {1'b1, 5'd0, 16'h8000});
    check("reinit_ntxn", 32'(n_txn - base), 32'd18);
    check("reinit_last_rd", {log_mode[base + 16], log_reg[base + 16]}, 32'd0);
    check("reinit_an", {log_mode[base + 17], log_reg[base + 17], log_data[base + 17]}, {1'b1, 5'd0, 16'h1200});
    check("reinit_error", 32'(init_error), 32'd1);
    check("final_overlap", 32'(overlaps), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
